tlb_pipe: RTL

- Parametrised fully-associative LoongArch TLB: TLBNUM entries, NPORT independent search ports.
- Search is registered, with results one cycle after the request.
- Contains a multi-cycle INVTLB sweep engine with a start/busy/done handshake, and a free-running replacement-index counter for TLBFILL.
- Sits between the IF/EX address-translation stages and CSR/TLB-instruction logic in the pipeline.

---
 rtl/tlb_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/tlb_pipe.sv
// Fully-associative LoongArch TLB with NPORT search ports, INVTLB sweep engine and TLBFILL index.
// Latency: search results 1 cycle after s_req; INVTLB takes TLBNUM sweep cycles plus one DONE cycle.
// Backpressure: none; searches are always accepted, inv_start is ignored unless the sweep engine is idle.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   s_req/s_vppn/s_va_bit12/s_asid -> s_rvalid/s_found/s_index/s_ppn/s_ps/s_plv/s_mat/s_d/s_v
//                               packed per-port search request / registered result (port 0 = fetch)
//   inv_start/inv_op/inv_asid/inv_vppn -> inv_busy/inv_done
//                               INVTLB sweep handshake
//   we/w_index/w_*              entry write; r_index/r_* combinational entry read
//   rand_index                  free-running TLBFILL replacement index
// Optional: define TLB_PERF_CNT_EN to add 32-bit hit_cnt, miss_cnt and inv_cnt outputs.

module tlb_pipe #(
    parameter int TLBNUM = 16,
    parameter int NPORT  = 2,
    localparam int IW    = $clog2(TLBNUM)
) (
    input  logic                clk,
    input  logic                reset,
    // search ports
    input  logic [NPORT-1:0]    s_req,
    input  logic [NPORT*19-1:0] s_vppn,
    input  logic [NPORT-1:0]    s_va_bit12,
    input  logic [NPORT*10-1:0] s_asid,
    output logic [NPORT-1:0]    s_rvalid,
    output logic [NPORT-1:0]    s_found,
    output logic [NPORT*IW-1:0] s_index,
    output logic [NPORT*20-1:0] s_ppn,
    output logic [NPORT*6-1:0]  s_ps,
    output logic [NPORT*2-1:0]  s_plv,
    output logic [NPORT*2-1:0]  s_mat,
    output logic [NPORT-1:0]    s_d,
    output logic [NPORT-1:0]    s_v,
    // INVTLB
    input  logic                inv_start,
    input  logic [4:0]          inv_op,
    input  logic [9:0]          inv_asid,
    input  logic [18:0]         inv_vppn,
    output logic                inv_busy,
    output logic                inv_done,
    // write port
    input  logic                we,
    input  logic [IW-1:0]       w_index,
    input  logic                w_e,
    input  logic [18:0]         w_vppn,
    input  logic [5:0]          w_ps,
    input  logic [9:0]          w_asid,
    input  logic                w_g,
    input  logic [19:0]         w_ppn0,
    input  logic [19:0]         w_ppn1,
    input  logic [1:0]          w_plv0,
    input  logic [1:0]          w_plv1,
    input  logic [1:0]          w_mat0,
    input  logic [1:0]          w_mat1,
    input  logic                w_d0,
    input  logic                w_d1,
    input  logic                w_v0,
    input  logic                w_v1,
    // read port
    input  logic [IW-1:0]       r_index,
    output logic                r_e,
    output logic [18:0]         r_vppn,
    output logic [5:0]          r_ps,
    output logic [9:0]          r_asid,
    output logic                r_g,
    output logic [19:0]         r_ppn0,
    output logic [19:0]         r_ppn1,
    output logic [1:0]          r_plv0,
    output logic [1:0]          r_plv1,
    output logic [1:0]          r_mat0,
    output logic [1:0]          r_mat1,
    output logic                r_d0,
    output logic                r_d1,
    output logic                r_v0,
    output logic                r_v1,
    output logic [IW-1:0]       rand_index
`ifdef TLB_PERF_CNT_EN
    ,
    output logic [31:0]         hit_cnt,
    output logic [31:0]         miss_cnt,
    output logic [31:0]         inv_cnt
`endif
);

    typedef struct packed {
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
        logic [19:0] ppn0;
        logic [19:0] ppn1;
        logic [1:0]  plv0;
        logic [1:0]  plv1;
        logic [1:0]  mat0;
        logic [1:0]  mat1;
        logic        d0;
        logic        d1;
        logic        v0;
        logic        v1;
    } tlb_ent_t;

    typedef struct packed {
        logic          found;
        logic [IW-1:0] index;
        logic [19:0]   ppn;
        logic [5:0]    ps;
        logic [1:0]    plv;
        logic [1:0]    mat;
        logic          d;
        logic          v;
    } srch_res_t;

    typedef enum logic [1:0] {INV_IDLE, INV_SWEEP, INV_DONE} inv_state_e;

    // E bits live apart from the entry payload because only they are reset.
    tlb_ent_t    ent_q [TLBNUM];
    logic [TLBNUM-1:0] e_q;

    // A 2MB page (PS=21) ignores the low 9 VPPN bits.
    function automatic logic vppn_eq(input tlb_ent_t ent, input logic [18:0] vppn);
        if (ent.ps == 6'd21) return ent.vppn[18:9] == vppn[18:9];
        return ent.vppn == vppn;
    endfunction

    function automatic logic inv_qual(input tlb_ent_t ent, input logic [4:0] op,
                                      input logic [9:0] asid, input logic [18:0] vppn);
        logic asid_eq;
        logic va_eq;
        asid_eq = (ent.asid == asid);
        va_eq   = vppn_eq(ent, vppn);
        case (op)
            5'd0, 5'd1: return 1'b1;
            5'd2:       return ent.g;
            5'd3:       return !ent.g;
            5'd4:       return !ent.g && asid_eq;
            5'd5:       return !ent.g && asid_eq && va_eq;
            5'd6:       return (ent.g || asid_eq) && va_eq;
            default:    return 1'b0;
        endcase
    endfunction

    // ---------------- search ----------------
    logic [NPORT-1:0] hit_any;
    logic [NPORT-1:0] pg_sel;
    logic [IW-1:0]    hit_idx [NPORT];
    srch_res_t        res_d   [NPORT];
    srch_res_t        res_q   [NPORT];

    always_comb begin
        hit_any = '0;
        pg_sel  = '0;
        for (int p = 0; p < NPORT; p++) begin
            hit_idx[p] = '0;
            res_d[p]   = '0;
            // Scan downwards so the lowest matching index is the one left standing.
            for (int i = TLBNUM - 1; i >= 0; i--) begin
                if (e_q[i] && (ent_q[i].g || ent_q[i].asid == s_asid[p*10 +: 10])
                    && vppn_eq(ent_q[i], s_vppn[p*19 +: 19])) begin
                    hit_any[p] = 1'b1;
                    hit_idx[p] = IW'(i);
                end
            end
            pg_sel[p] = (ent_q[hit_idx[p]].ps == 6'd21) ? s_vppn[p*19 + 8] : s_va_bit12[p];
            if (hit_any[p]) begin
                res_d[p].found = 1'b1;
                res_d[p].index = hit_idx[p];
                res_d[p].ps    = ent_q[hit_idx[p]].ps;
                if (pg_sel[p]) begin
                    res_d[p].ppn = ent_q[hit_idx[p]].ppn1;
                    res_d[p].plv = ent_q[hit_idx[p]].plv1;
                    res_d[p].mat = ent_q[hit_idx[p]].mat1;
                    res_d[p].d   = ent_q[hit_idx[p]].d1;
                    res_d[p].v   = ent_q[hit_idx[p]].v1;
                end else begin
                    res_d[p].ppn = ent_q[hit_idx[p]].ppn0;
                    res_d[p].plv = ent_q[hit_idx[p]].plv0;
                    res_d[p].mat = ent_q[hit_idx[p]].mat0;
                    res_d[p].d   = ent_q[hit_idx[p]].d0;
                    res_d[p].v   = ent_q[hit_idx[p]].v0;
                end
            end
        end
    end

    // Results only update on a request so idle ports keep their last translation.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_rvalid <= '0;
            for (int p = 0; p < NPORT; p++) res_q[p] <= '0;
        end else begin
            s_rvalid <= s_req;
            for (int p = 0; p < NPORT; p++) begin
                if (s_req[p]) res_q[p] <= res_d[p];
            end
        end
    end

    always_comb begin
        s_found = '0;
        s_index = '0;
        s_ppn   = '0;
        s_ps    = '0;
        s_plv   = '0;
        s_mat   = '0;
        s_d     = '0;
        s_v     = '0;
        for (int p = 0; p < NPORT; p++) begin
            s_found[p]          = res_q[p].found;
            s_index[p*IW +: IW] = res_q[p].index;
            s_ppn[p*20 +: 20]   = res_q[p].ppn;
            s_ps[p*6 +: 6]      = res_q[p].ps;
            s_plv[p*2 +: 2]     = res_q[p].plv;
            s_mat[p*2 +: 2]     = res_q[p].mat;
            s_d[p]              = res_q[p].d;
            s_v[p]              = res_q[p].v;
        end
    end

    // ---------------- INVTLB sweep ----------------
    inv_state_e    state_q, state_d;
    logic [IW-1:0] inv_cnt_q, inv_cnt_d;
    logic [4:0]    op_q;
    logic [9:0]    op_asid_q;
    logic [18:0]   op_vppn_q;
    logic          sweep_clr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= INV_IDLE;
            inv_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            inv_cnt_q <= inv_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == INV_IDLE && inv_start) begin
            op_q      <= inv_op;
            op_asid_q <= inv_asid;
            op_vppn_q <= inv_vppn;
        end
    end

    always_comb begin
        state_d   = state_q;
        inv_cnt_d = inv_cnt_q;
        case (state_q)
            INV_IDLE: begin
                if (inv_start) begin
                    inv_cnt_d = '0;
                    // Undefined ops complete without touching the table.
                    state_d   = (inv_op > 5'd6) ? INV_DONE : INV_SWEEP;
                end
            end
            INV_SWEEP: begin
                if (inv_cnt_q == IW'(TLBNUM - 1)) state_d = INV_DONE;
                else                              inv_cnt_d = inv_cnt_q + IW'(1);
            end
            INV_DONE: state_d = INV_IDLE;
            default:  state_d = INV_IDLE;
        endcase
    end

    assign inv_busy  = (state_q == INV_SWEEP);
    assign inv_done  = (state_q == INV_DONE);
    assign sweep_clr = inv_busy && inv_qual(ent_q[inv_cnt_q], op_q, op_asid_q, op_vppn_q);

    // ---------------- storage ----------------
    always_ff @(posedge clk) begin
        if (we) begin
            ent_q[w_index] <= '{vppn: w_vppn, ps: w_ps, asid: w_asid, g: w_g,
                                ppn0: w_ppn0, ppn1: w_ppn1, plv0: w_plv0, plv1: w_plv1,
                                mat0: w_mat0, mat1: w_mat1, d0: w_d0, d1: w_d1,
                                v0: w_v0, v1: w_v1};
        end
    end

    // The write is ordered after the sweep clear so it wins on a shared index.
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q <= '0;
        end else begin
            if (sweep_clr) e_q[inv_cnt_q] <= 1'b0;
            if (we)        e_q[w_index]   <= w_e;
        end
    end

    assign r_e    = e_q[r_index];
    assign r_vppn = ent_q[r_index].vppn;
    assign r_ps   = ent_q[r_index].ps;
    assign r_asid = ent_q[r_index].asid;
    assign r_g    = ent_q[r_index].g;
    assign r_ppn0 = ent_q[r_index].ppn0;
    assign r_ppn1 = ent_q[r_index].ppn1;
    assign r_plv0 = ent_q[r_index].plv0;
    assign r_plv1 = ent_q[r_index].plv1;
    assign r_mat0 = ent_q[r_index].mat0;
    assign r_mat1 = ent_q[r_index].mat1;
    assign r_d0   = ent_q[r_index].d0;
    assign r_d1   = ent_q[r_index].d1;
    assign r_v0   = ent_q[r_index].v0;
    assign r_v1   = ent_q[r_index].v1;

    // ---------------- TLBFILL index ----------------
    always_ff @(posedge clk) begin
        if (reset) rand_index <= '0;
        else       rand_index <= rand_index + IW'(1);
    end

`ifdef TLB_PERF_CNT_EN
    logic [31:0] hit_inc;
    logic [31:0] miss_inc;

    always_comb begin
        hit_inc  = '0;
        miss_inc = '0;
        for (int p = 0; p < NPORT; p++) begin
            hit_inc  = hit_inc  + {31'd0, s_rvalid[p] &  s_found[p]};
            miss_inc = miss_inc + {31'd0, s_rvalid[p] & ~s_found[p]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
            inv_cnt  <= '0;
        end else begin
            hit_cnt  <= hit_cnt  + hit_inc;
            miss_cnt <= miss_cnt + miss_inc;
            inv_cnt  <= inv_cnt  + {31'd0, inv_done};
        end
    end
`endif

endmodule
